// File: rtl/pll_seq_pkg.sv
// ============================================================================
// Module      : pll_seq_pkg
// Description : Shared types and constants for the PLL reset/lock sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pll_seq_pkg;

    localparam int RETRY_W = 4;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } pll_state_e;

endpackage : pll_seq_pkg

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module      : sync_2ff
// Description : Generic two-flop synchronizer, asynchronous active-high reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : sync_2ff

`default_nettype wire

// File: rtl/pll_reset_seq.sv
// ============================================================================
// Module      : pll_reset_seq
// Description : PLL reset/lock sequencer; qualifies lock before releasing
//               sys_rst. Macro PLL_SEQ_RETRY_LIMIT_EN enables the FAIL state.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pll_reset_seq
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               pll_locked,
    input  logic               relock_req,
    output logic               pll_rst,
    output logic               sys_rst,
    output logic               ready,
    output logic               lock_lost,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic               fail
);

    localparam int CNT_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A : STABLE_CYCLES;
    localparam int CNT_W     = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] c_rst_last    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_to_last     = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_stable_last = CNT_W'(STABLE_CYCLES - 1);

    pll_state_e         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [RETRY_W-1:0] r_retry;
    logic               r_pll_rst;
    logic               r_sys_rst;
    logic               r_ready;
    logic               r_lock_lost;
    logic               w_locked_s;
    logic [RETRY_W-1:0] w_retry_inc;

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .i_d (pll_locked),
        .o_q (w_locked_s)
    );

    assign w_retry_inc = (r_retry == {RETRY_W{1'b1}}) ? r_retry : r_retry + RETRY_W'(1);

`ifdef PLL_SEQ_RETRY_LIMIT_EN
    logic r_fail;
`else
    logic [RETRY_W-1:0] w_unused_max_retries;
    assign w_unused_max_retries = RETRY_W'(MAX_RETRIES);
`endif

    // cnt counts cycles spent in the current state; cleared on every state entry.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_state     <= PLL_RST;
            r_cnt       <= '0;
            r_retry     <= '0;
            r_pll_rst   <= 1'b1;
            r_sys_rst   <= 1'b1;
            r_ready     <= 1'b0;
            r_lock_lost <= 1'b0;
`ifdef PLL_SEQ_RETRY_LIMIT_EN
            r_fail      <= 1'b0;
`endif
        end else begin
            r_lock_lost <= (r_state == RUN) && !w_locked_s;
            r_cnt       <= r_cnt + CNT_W'(1);
            if (relock_req) begin
                r_state   <= PLL_RST;
                r_cnt     <= '0;
                r_retry   <= '0;
                r_pll_rst <= 1'b1;
                r_sys_rst <= 1'b1;
                r_ready   <= 1'b0;
`ifdef PLL_SEQ_RETRY_LIMIT_EN
                r_fail    <= 1'b0;
`endif
            end else begin
                case (r_state)
                    PLL_RST: begin
                        if (r_cnt == c_rst_last) begin
                            r_state   <= WAIT_LOCK;
                            r_cnt     <= '0;
                            r_pll_rst <= 1'b0;
                        end
                    end
                    WAIT_LOCK: begin
                        if (w_locked_s) begin
                            r_state <= STABLE;
                            r_cnt   <= '0;
                        end else if (r_cnt == c_to_last) begin
                            r_retry   <= w_retry_inc;
                            r_cnt     <= '0;
                            r_pll_rst <= 1'b1;
`ifdef PLL_SEQ_RETRY_LIMIT_EN
                            if (w_retry_inc >= RETRY_W'(MAX_RETRIES)) begin
                                r_state <= FAIL;
                                r_fail  <= 1'b1;
                            end else begin
                                r_state <= PLL_RST;
                            end
`else
                            r_state   <= PLL_RST;
`endif
                        end
                    end
                    STABLE: begin
                        // a single dropout restarts the window without counting as a retry
                        if (!w_locked_s) begin
                            r_state <= WAIT_LOCK;
                            r_cnt   <= '0;
                        end else if (r_cnt == c_stable_last) begin
                            r_state   <= RUN;
                            r_cnt     <= '0;
                            r_retry   <= '0;
                            r_sys_rst <= 1'b0;
                            r_ready   <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (!w_locked_s) begin
                            r_state   <= PLL_RST;
                            r_cnt     <= '0;
                            r_pll_rst <= 1'b1;
                            r_sys_rst <= 1'b1;
                            r_ready   <= 1'b0;
                        end
                    end
`ifdef PLL_SEQ_RETRY_LIMIT_EN
                    FAIL: begin
                        r_state <= FAIL;
                    end
`endif
                    default: begin
                        r_state   <= PLL_RST;
                        r_cnt     <= '0;
                        r_pll_rst <= 1'b1;
                        r_sys_rst <= 1'b1;
                        r_ready   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign pll_rst   = r_pll_rst;
    assign sys_rst   = r_sys_rst;
    assign ready     = r_ready;
    assign lock_lost = r_lock_lost;
    assign retry_cnt = r_retry;
`ifdef PLL_SEQ_RETRY_LIMIT_EN
    assign fail      = r_fail;
`else
    assign fail      = 1'b0;
`endif

endmodule : pll_reset_seq

`default_nettype wire

// File: tb/tb_pll_reset_seq.sv
// ============================================================================
// Module      : tb_pll_reset_seq
// Description : Self-checking bench for pll_reset_seq, cycle-stamped scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pll_reset_seq;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 20;
    localparam int STABLE_CYCLES = 8;
    localparam int MAX_RETRIES   = 2;

    logic       refclk     = 1'b0;
    logic       rst        = 1'b1;
    logic       pll_locked = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       lock_lost;
    logic [3:0] retry_cnt;
    logic       fail;
    logic [8:0] w_obs;

    pll_reset_seq #(
        .RST_CYCLES    (RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .STABLE_CYCLES (STABLE_CYCLES),
        .MAX_RETRIES   (MAX_RETRIES)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .relock_req (relock_req),
        .pll_rst    (pll_rst),
        .sys_rst    (sys_rst),
        .ready      (ready),
        .lock_lost  (lock_lost),
        .retry_cnt  (retry_cnt),
        .fail       (fail)
    );

    always #5 refclk = ~refclk;

    assign w_obs = {pll_rst, sys_rst, ready, lock_lost, fail, retry_cnt};

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;

    always @(posedge refclk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        string      tag;
        logic [8:0] vec;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output vector layout: {pll_rst, sys_rst, ready, lock_lost, fail, retry_cnt}
    function automatic logic [8:0] ov(input logic p, input logic s, input logic r,
                                      input logic l, input logic f, input int rc);
        logic [31:0] v;
        v = rc;
        return {p, s, r, l, f, v[3:0]};
    endfunction

    function automatic void exp_at(input int at, input string tag, input logic [8:0] v);
        exp_t e;
        e.at  = at;
        e.tag = tag;
        e.vec = v;
        sb.push_back(e);
    endfunction

    always @(negedge refclk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == cyc) begin
                chk(sb[i].tag, 32'(w_obs), 32'(sb[i].vec));
                sb.delete(i);
            end else if (sb[i].at < cyc) begin
                chk({"late_", sb[i].tag}, cyc, sb[i].at);
                sb.delete(i);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge refclk);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge refclk);
    endtask

    initial begin
        int c0, c1, c, e, l, r, q, s;

        tick(3);
        chk("reset_state", 32'(w_obs), 32'(ov(1, 1, 0, 0, 0, 0)));

        // Bring-up: lock arrives 5 cycles after pll_rst falls
        c0 = cyc;
        exp_at(c0 + 1, "prst_hold1", ov(1, 1, 0, 0, 0, 0));
        exp_at(c0 + 3, "prst_hold3", ov(1, 1, 0, 0, 0, 0));
        exp_at(c0 + 4, "prst_rel",   ov(0, 1, 0, 0, 0, 0));
        rst = 1'b0;
        wait_cyc(c0 + 9);
        c1 = cyc;
        exp_at(c1 + 10, "stable_win", ov(0, 1, 0, 0, 0, 0));
        exp_at(c1 + 11, "run_ready",  ov(0, 0, 1, 0, 0, 0));
        pll_locked = 1'b1;
        wait_cyc(c1 + 14);

        // Lock loss in RUN, then lock never returns
        c = cyc;
        exp_at(c + 2, "loss_still_run", ov(0, 0, 1, 0, 0, 0));
        exp_at(c + 3, "loss_pulse",     ov(1, 1, 0, 1, 0, 0));
        exp_at(c + 4, "loss_pulse_end", ov(1, 1, 0, 0, 0, 0));
        exp_at(c + 7, "loss_reseq",     ov(0, 1, 0, 0, 0, 0));
        e = c + 7;
        exp_at(e + 19, "to_wait1",  ov(0, 1, 0, 0, 0, 0));
        exp_at(e + 20, "to_retry1", ov(1, 1, 0, 0, 0, 1));
        exp_at(e + 43, "to_wait2",  ov(0, 1, 0, 0, 0, 1));
`ifdef PLL_SEQ_RETRY_LIMIT_EN
        exp_at(e + 44,  "to_fail",   ov(1, 1, 0, 0, 1, 2));
        exp_at(e + 100, "fail_hold", ov(1, 1, 0, 0, 1, 2));
`else
        for (int k = 2; k <= 16; k++)
            exp_at(e + 20 + 24 * (k - 1), $sformatf("to_retry%0d", k),
                   ov(1, 1, 0, 0, 0, (k > 15) ? 15 : k));
        exp_at(e + 379, "to_sat_wait", ov(0, 1, 0, 0, 0, 15));
`endif
        pll_locked = 1'b0;
        wait_cyc(e + 382);

        // relock from FAIL (or from a retry loop without the limit)
        c = cyc;
        exp_at(c + 1, "relock_clr", ov(1, 1, 0, 0, 0, 0));
        exp_at(c + 5, "relock_rel", ov(0, 1, 0, 0, 0, 0));
        relock_req = 1'b1;
        tick(1);
        relock_req = 1'b0;

        // One-cycle dropout after 5 stable cycles
        l = c + 5;
        wait_cyc(l);
        exp_at(l + 9,  "glitch_noretry",  ov(0, 1, 0, 0, 0, 0));
        exp_at(l + 11, "glitch_no_early", ov(0, 1, 0, 0, 0, 0));
        exp_at(l + 17, "glitch_window",   ov(0, 1, 0, 0, 0, 0));
        exp_at(l + 18, "glitch_run",      ov(0, 0, 1, 0, 0, 0));
        pll_locked = 1'b1;
        wait_cyc(l + 6);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        wait_cyc(l + 22);

        // relock while in RUN with lock held
        r = cyc;
        exp_at(r + 1,  "run_relock",     ov(1, 1, 0, 0, 0, 0));
        exp_at(r + 5,  "run_relock_rel", ov(0, 1, 0, 0, 0, 0));
        exp_at(r + 13, "run_relock_win", ov(0, 1, 0, 0, 0, 0));
        exp_at(r + 14, "run_relock_rdy", ov(0, 0, 1, 0, 0, 0));
        relock_req = 1'b1;
        tick(1);
        relock_req = 1'b0;
        wait_cyc(r + 18);

        // relock coincident with the lock-loss event
        q = cyc;
        exp_at(q + 3, "coinc_pulse", ov(1, 1, 0, 1, 0, 0));
        exp_at(q + 4, "coinc_end",   ov(1, 1, 0, 0, 0, 0));
        exp_at(q + 7, "coinc_rel",   ov(0, 1, 0, 0, 0, 0));
        pll_locked = 1'b0;
        wait_cyc(q + 2);
        relock_req = 1'b1;
        tick(1);
        relock_req = 1'b0;
        wait_cyc(q + 4);
        pll_locked = 1'b1;

        // Asynchronous reset while in STABLE
        wait_cyc(q + 11);
        chk("async_pre", 32'(w_obs), 32'(ov(0, 1, 0, 0, 0, 0)));
        #2 rst = 1'b1;
        #1 chk("async_rst", 32'(w_obs), 32'(ov(1, 1, 0, 0, 0, 0)));
        tick(2);
        s = cyc;
        exp_at(s + 3,  "post_rst_hold", ov(1, 1, 0, 0, 0, 0));
        exp_at(s + 4,  "post_rst_rel",  ov(0, 1, 0, 0, 0, 0));
        exp_at(s + 12, "post_rst_win",  ov(0, 1, 0, 0, 0, 0));
        exp_at(s + 13, "post_rst_rdy",  ov(0, 0, 1, 0, 0, 0));
        rst = 1'b0;
        wait_cyc(s + 16);
        tick(1);
        chk("sb_drain", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_pll_reset_seq

`default_nettype wire
